// File: rtl/exec_pkg.sv
// Shared definitions for the execute stage that follows the 16-bit barrel
// shifter: datapath widths, ALU opcode encodings and status-register bit
// positions.
package exec_pkg;

  // Datapath width (matches the shifter output) and register-index width
  // (8-entry register file).
  localparam int W      = 16;
  localparam int RIDX_W = 3;

  // ALU opcodes.
  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_MVN = 2'b11;

  // Bit positions inside the {V,N,Z} status register.
  localparam int ST_Z = 0;
  localparam int ST_N = 1;
  localparam int ST_V = 2;

endpackage

// File: rtl/alu16.sv
// Combinational ALU for the execute stage.
// Ports:
//   a   in  W  operand A (already forced to zero on the MOV path)
//   b   in  W  operand B (shifter output)
//   op  in  2  ALU_ADD / ALU_SUB / ALU_AND / ALU_MVN
//   r   out W  result, modulo 2^W (carry-out discarded)
//   v   out 1  signed overflow (ADD/SUB only, 0 otherwise)
//   n   out 1  result sign bit
//   z   out 1  result is zero
module alu16 #(
  parameter int W = exec_pkg::W
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [1:0]   op,
  output logic [W-1:0] r,
  output logic         v,
  output logic         n,
  output logic         z
);
  import exec_pkg::*;

  // NOTE: every output of an always_comb block gets a default first, so no
  // path through the case statement can leave it unassigned and infer a latch.
  always_comb begin
    r = '0;
    v = 1'b0;
    unique case (op)
      ALU_ADD: begin
        r = a + b;
        // Overflow: same-signed operands produced a result of the other sign.
        v = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
      end
      ALU_SUB: begin
        r = a + ~b + W'(1);
        // Overflow: operands of differing sign and the result flipped sign.
        v = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]);
      end
      ALU_AND: r = a & b;
      ALU_MVN: r = ~b;
      default: r = '0;
    endcase
  end

  assign n = r[W-1];
  assign z = (r == '0);

endmodule

// File: rtl/alu_exec_stage.sv
// Two-stage execute pipeline downstream of the barrel shifter.
// Stage 1 captures the operands and control of an accepted op; stage 2 holds
// the ALU result, its writeback index, and drives the status register.
// Valid/ready handshake on both sides, one op per cycle at full rate.
// Ports:
//   clk        in   1       rising-edge clock
//   reset      in   1       synchronous, active-high; drops all in-flight ops
//   in_valid   in   1       upstream op valid
//   in_ready   out  1       stage can accept an op this cycle
//   ain        in   W       operand A (register file read)
//   sout       in   W       operand B after the shifter
//   aluop      in   2       00 ADD, 01 SUB, 10 AND, 11 MVN
//   asel       in   1       force operand A to zero (MOV path)
//   loads      in   1       op updates the status register
//   wdst       in   RIDX_W  writeback register index carried with the op
//   out_valid  out  1       result valid
//   out_ready  in   1       downstream accepts the result
//   c          out  W       result
//   cdst       out  RIDX_W  writeback index of the result
//   status     out  3       {V,N,Z}
module alu_exec_stage #(
  parameter int W      = exec_pkg::W,
  parameter int RIDX_W = exec_pkg::RIDX_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [W-1:0]      ain,
  input  logic [W-1:0]      sout,
  input  logic [1:0]        aluop,
  input  logic              asel,
  input  logic              loads,
  input  logic [RIDX_W-1:0] wdst,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [W-1:0]      c,
  output logic [RIDX_W-1:0] cdst,
  output logic [2:0]        status
);
  import exec_pkg::*;

  // Stage 1 registers.
  logic              s1_valid;
  logic [W-1:0]      s1_a;
  logic [W-1:0]      s1_b;
  logic [1:0]        s1_op;
  logic              s1_asel;
  logic              s1_loads;
  logic [RIDX_W-1:0] s1_wdst;

  // Stage 2 occupancy; its payload lives directly in c/cdst.
  logic              s2_valid;

  logic              accept;
  logic              s2_adv;
  logic              out_xfer;
  logic [W-1:0]      a_eff;
  logic [W-1:0]      alu_r;
  logic              alu_v;
  logic              alu_n;
  logic              alu_z;

  // Stage 1 moves forward when stage 2 is empty or is emptying this cycle.
  assign s2_adv    = s1_valid && (!s2_valid || out_ready);
  // Stage 1 can take a new op when empty or when its op leaves this cycle,
  // which lets a full pipeline accept, advance and emit in the same cycle.
  assign in_ready  = !reset && (!s1_valid || s2_adv);
  assign accept    = in_valid && in_ready;
  assign out_valid = s2_valid;
  assign out_xfer  = s2_valid && out_ready;

  assign a_eff = s1_asel ? '0 : s1_a;

  alu16 #(.W(W)) u_alu (
    .a  (a_eff),
    .b  (s1_b),
    .op (s1_op),
    .r  (alu_r),
    .v  (alu_v),
    .n  (alu_n),
    .z  (alu_z)
  );

  // NOTE: stage-1 payload registers carry no reset; they are only observed
  // when s1_valid is set, so resetting the valid bit alone is sufficient.
  always_ff @(posedge clk) begin
    if (accept) begin
      s1_a     <= ain;
      s1_b     <= sout;
      s1_op    <= aluop;
      s1_asel  <= asel;
      s1_loads <= loads;
      s1_wdst  <= wdst;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      c        <= '0;
      cdst     <= '0;
      status   <= 3'b000;
    end else begin
      // Stage 1 occupancy: a new accept refills it even if its op advances.
      if (accept) begin
        s1_valid <= 1'b1;
      end else if (s2_adv) begin
        s1_valid <= 1'b0;
      end

      // Stage 2: an advancing op replaces whatever is leaving; otherwise an
      // output transfer empties the stage. Without either, c/cdst hold.
      if (s2_adv) begin
        s2_valid <= 1'b1;
        c        <= alu_r;
        cdst     <= s1_wdst;
        if (s1_loads) begin
          status[ST_V] <= alu_v;
          status[ST_N] <= alu_n;
          status[ST_Z] <= alu_z;
        end
      end else if (out_xfer) begin
        s2_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_exec_stage.sv
// Self-checking bench for alu_exec_stage. A queue-based reference model
// computes each accepted op's result and flags from signed/unsigned integer
// arithmetic and tracks the architectural status value in program order.
module tb_alu_exec_stage;
  localparam int W      = 16;
  localparam int RIDX_W = 3;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [W-1:0]      ain = '0;
  logic [W-1:0]      sout = '0;
  logic [1:0]        aluop = 2'b00;
  logic              asel = 1'b0;
  logic              loads = 1'b0;
  logic [RIDX_W-1:0] wdst = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [W-1:0]      c;
  logic [RIDX_W-1:0] cdst;
  logic [2:0]        status;

  alu_exec_stage dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .ain       (ain),
    .sout      (sout),
    .aluop     (aluop),
    .asel      (asel),
    .loads     (loads),
    .wdst      (wdst),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .c         (c),
    .cdst      (cdst),
    .status    (status)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0]      c;
    logic [RIDX_W-1:0] cdst;
    logic [2:0]        st;
  } exp_t;

  exp_t              exp_q[$];
  logic [2:0]        model_status = 3'b000;
  int                n_checks = 0;
  int                n_errors = 0;
  int                n_out = 0;
  logic              accepted = 1'b0;
  logic [W-1:0]      last_c = '0;
  logic [RIDX_W-1:0] last_cdst = '0;
  logic [2:0]        last_st = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, expv, $time);
    end
  endtask

  // Reference: result from plain arithmetic, overflow from the true signed
  // value falling outside the W-bit range, status updated in program order.
  task automatic model_push(input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic [1:0] op, input logic sel,
                            input logic ld, input logic [RIDX_W-1:0] dst);
    logic [W-1:0] ap;
    logic [W-1:0] r;
    int           sa, sb, s;
    logic         v;
    exp_t         e;
    ap = sel ? '0 : a;
    sa = $signed(ap);
    sb = $signed(b);
    v  = 1'b0;
    case (op)
      2'b00: begin r = ap + b; s = sa + sb; v = (s > 32767) || (s < -32768); end
      2'b01: begin r = ap - b; s = sa - sb; v = (s > 32767) || (s < -32768); end
      2'b10: r = ap & b;
      default: r = ~b;
    endcase
    if (ld) model_status = {v, r[W-1], (r == 0)};
    e.c    = r;
    e.cdst = dst;
    e.st   = model_status;
    exp_q.push_back(e);
  endtask

  // One clock cycle: observe at the falling edge, update the model with the
  // handshakes that the coming rising edge will commit, then return #1 after it.
  task automatic step();
    logic acc, xf;
    exp_t e;
    @(negedge clk);
    if (out_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("spurious_out_valid", out_valid, 0);
      end else begin
        check("c", c, exp_q[0].c);
        check("cdst", cdst, exp_q[0].cdst);
        check("status", status, exp_q[0].st);
      end
    end
    acc = in_valid && (in_ready === 1'b1);
    xf  = (out_valid === 1'b1) && out_ready;
    if (reset) begin
      exp_q.delete();
      model_status = 3'b000;
      acc = 1'b0;
    end else begin
      if (xf && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_out++;
        last_c    = e.c;
        last_cdst = e.cdst;
        last_st   = e.st;
      end
      if (acc) model_push(ain, sout, aluop, asel, loads, wdst);
    end
    accepted = acc;
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] op,
                        input logic sel, input logic ld, input logic [RIDX_W-1:0] dst);
    ain = a; sout = b; aluop = op; asel = sel; loads = ld; wdst = dst;
  endtask

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] op,
                      input logic sel, input logic ld, input logic [RIDX_W-1:0] dst);
    int k;
    set_op(a, b, op, sel, ld, dst);
    in_valid = 1'b1;
    k = 0;
    do begin
      step();
      k++;
    end while (!accepted && k < 20);
    check("accept_timeout", accepted, 1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int k;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    k = 0;
    while (exp_q.size() > 0 && k < 50) begin
      step();
      k++;
    end
    check("drain_left", exp_q.size(), 0);
  endtask

  task automatic rand_op();
    set_op(W'($urandom), W'($urandom), 2'($urandom), ($urandom % 8) == 0,
           1'($urandom), RIDX_W'($urandom));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;

    // Reset state.
    reset = 1'b1;
    step();
    step();
    check("rst_out_valid", out_valid, 0);
    check("rst_c", c, 0);
    check("rst_cdst", cdst, 0);
    check("rst_status", status, 0);
    check("rst_in_ready", in_ready, 0);
    reset = 1'b0;
    #1;
    check("post_rst_in_ready", in_ready, 1);

    // 1: ADD 5+3, latency of two edges.
    out_ready = 1'b1;
    set_op(16'h0005, 16'h0003, 2'b00, 1'b0, 1'b1, 3'd2);
    in_valid = 1'b1;
    step();
    check("t1_accept", accepted, 1);
    in_valid = 1'b0;
    check("t1_lat1_out_valid", out_valid, 0);
    step();
    check("t1_lat2_out_valid", out_valid, 1);
    check("t1_c", c, 16'h0008);
    check("t1_cdst", cdst, 2);
    check("t1_status", status, 3'b000);
    drain();

    // 2: SUB zero result and SUB signed overflow.
    send(16'h0003, 16'h0003, 2'b01, 1'b0, 1'b1, 3'd1);
    drain();
    check("t2a_c", last_c, 16'h0000);
    check("t2a_status", last_st, 3'b001);
    send(16'h8000, 16'h0001, 2'b01, 1'b0, 1'b1, 3'd3);
    drain();
    check("t2b_c", last_c, 16'h7FFF);
    check("t2b_status", last_st, 3'b100);

    // 3: ADD overflow, then a non-loading op leaves status alone.
    send(16'h7FFF, 16'h0001, 2'b00, 1'b0, 1'b1, 3'd4);
    drain();
    check("t3a_c", last_c, 16'h8000);
    check("t3a_status", last_st, 3'b110);
    send(16'h0000, 16'h0000, 2'b00, 1'b0, 1'b0, 3'd5);
    drain();
    check("t3b_c", last_c, 16'h0000);
    check("t3b_status", status, 3'b110);

    // 4: MVN, AND, MOV path.
    send(16'h1111, 16'h00FF, 2'b11, 1'b0, 1'b1, 3'd6);
    drain();
    check("t4_mvn_c", last_c, 16'hFF00);
    check("t4_mvn_status", last_st, 3'b010);
    send(16'hF0F0, 16'h0FF0, 2'b10, 1'b0, 1'b1, 3'd7);
    drain();
    check("t4_and_c", last_c, 16'h00F0);
    send(16'h1234, 16'h0042, 2'b00, 1'b1, 1'b1, 3'd0);
    drain();
    check("t4_mov_c", last_c, 16'h0042);

    // 5: backpressure with four streamed ops.
    n0 = n_out;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    set_op(16'h0010, 16'h0001, 2'b00, 1'b0, 1'b1, 3'd4);
    step();
    check("t5_acc0", accepted, 1);
    set_op(16'h0020, 16'h0002, 2'b01, 1'b0, 1'b1, 3'd5);
    step();
    check("t5_acc1", accepted, 1);
    set_op(16'h00F0, 16'h0F0F, 2'b10, 1'b0, 1'b1, 3'd6);
    check("t5_in_ready_full", in_ready, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("t5_stall_no_accept", accepted, 0);
      check("t5_stall_out_valid", out_valid, 1);
    end
    out_ready = 1'b1;
    send(16'h00F0, 16'h0F0F, 2'b10, 1'b0, 1'b1, 3'd6);
    send(16'h0000, 16'h1234, 2'b11, 1'b0, 1'b1, 3'd7);
    drain();
    check("t5_emitted", n_out - n0, 4);
    check("t5_last_cdst", last_cdst, 7);

    // 6: reset with two ops in flight discards both.
    out_ready = 1'b0;
    send(16'h0000, 16'h0001, 2'b01, 1'b0, 1'b1, 3'd1);
    send(16'h7FFF, 16'h7FFF, 2'b00, 1'b0, 1'b1, 3'd2);
    check("t6_status_before", status, 3'b010);
    n0 = n_out;
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("t6_out_valid", out_valid, 0);
    check("t6_status", status, 3'b000);
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) step();
    check("t6_none_emitted", n_out - n0, 0);

    // Full-rate streaming: one result per cycle.
    n0 = n_out;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      rand_op();
      check("fr_in_ready", in_ready, 1);
      step();
      if (i >= 1) check("fr_out_valid", out_valid, 1);
    end
    drain();
    check("fr_emitted", n_out - n0, 20);

    // Randomized traffic with random backpressure and occasional reset.
    for (int i = 0; i < 400; i++) begin
      rand_op();
      in_valid  = ($urandom % 4) != 0;
      out_ready = ($urandom % 3) != 0;
      reset     = ($urandom % 100) == 0;
      step();
    end
    reset = 1'b0;
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
